dsp_mac_seq: RTL and testbench



---
 rtl/dsp_pkg.sv | 23 ++
 rtl/dsp_mac_seq_if.sv | 46 ++++
 rtl/res_fifo.sv | 56 +++++
 rtl/dsp_mac_seq.sv | 157 +++++++++++++++
 tb/tb_dsp_mac_seq.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_pkg.sv
// Shared constants for the DSP48A1 multiply-accumulate controller.
// Holds the slice data widths, the OPMODE field encodings and the
// burst-tracking state type.
package dsp_pkg;

  localparam int A_W = 18;
  localparam int B_W = 18;
  localparam int M_W = 36;
  localparam int P_W = 48;

  // OPMODE fields: bits[1:0] select X, bits[3:2] select Z
  localparam logic [7:0] OPM_X_M    = 8'h01;
  localparam logic [7:0] OPM_Z_ZERO = 8'h00;
  localparam logic [7:0] OPM_Z_P    = 8'h08;
  localparam logic [7:0] OPM_FIRST  = OPM_X_M | OPM_Z_ZERO;  // 8'h01
  localparam logic [7:0] OPM_ACC    = OPM_X_M | OPM_Z_P;     // 8'h09

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_ACC   = 1'b1
  } burst_state_e;

endpackage

// File: rtl/dsp_mac_seq_if.sv
// Bundle of the operand stream, the result stream and the DSP48A1 slice
// connections of dsp_mac_seq.
//   in_*   : operand beats (valid/ready, last marks end of burst)
//   res_*  : result FIFO head (valid/ready)
//   dsp_*  : slice A/B/OPMODE/clock enables/reset, and P coming back
// slave  = the controller, master = the environment around it.
interface dsp_mac_seq_if #(
  parameter int CNT_W = 12
);
  import dsp_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   in_a;
  logic [B_W-1:0]   in_b;
  logic             in_last;

  logic             res_valid;
  logic             res_ready;
  logic [P_W-1:0]   res_sum;
  logic [CNT_W-1:0] res_taps;
  logic             res_ovf;

  logic [A_W-1:0]   dsp_a;
  logic [B_W-1:0]   dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_cea;
  logic             dsp_ceb;
  logic             dsp_cem;
  logic             dsp_cep;
  logic             dsp_rst;
  logic [P_W-1:0]   dsp_p;

  modport slave (
    input  in_valid, in_a, in_b, in_last, res_ready, dsp_p,
    output in_ready, res_valid, res_sum, res_taps, res_ovf,
           dsp_a, dsp_b, dsp_opmode, dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_rst
  );

  modport master (
    output in_valid, in_a, in_b, in_last, res_ready, dsp_p,
    input  in_ready, res_valid, res_sum, res_taps, res_ovf,
           dsp_a, dsp_b, dsp_opmode, dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_rst
  );

endinterface

// File: rtl/res_fifo.sv
// Small result FIFO. Push and pop in the same cycle are both honoured.
// The head is read directly from the storage flops, so dout/valid change
// only on clock edges.
//   push/din  : write side
//   pop       : consumer handshake (ignored when empty)
//   valid/dout: head entry
module res_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= inc_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= inc_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign valid = (count != '0);
  assign dout  = mem[rd_ptr];

endmodule

// File: rtl/dsp_mac_seq.sv
// Upstream controller for one DSP48A1 slice used as an unsigned MAC.
// Operand pairs arrive as bursts; each beat is walked through the slice
// (A1/B1 -> M -> P) with matching clock enables, and the burst sum is
// captured into a result FIFO together with the tap count.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : operand stream, result stream and slice connections
//
// state    | meaning
// ST_FIRST | next accepted beat starts a burst (Z=0 at the P stage)
// ST_ACC   | inside a burst, next beats accumulate onto P
module dsp_mac_seq
  import dsp_pkg::*;
#(
  parameter int RES_DEPTH = 2,
  parameter int CNT_W     = 12
) (
  input logic         CLK,
  input logic         RST_N,
  dsp_mac_seq_if.slave bus
);

  localparam int CR_W  = $clog2(RES_DEPTH + 1);
  localparam int RES_W = P_W + CNT_W + 1;
  localparam logic [CNT_W-1:0] TAP_MAX = '1;

  burst_state_e     state;
  logic [1:0]       rst_cnt;
  logic [CR_W-1:0]  credits;
  logic [A_W-1:0]   a_hold;
  logic [B_W-1:0]   b_hold;
  logic [CNT_W-1:0] tap_cnt;
  logic             tap_ovf;
  logic [CNT_W-1:0] taps_nxt;
  logic             ovf_nxt;
  logic             v1, v2, v3;
  logic             first1;
  logic             last1, last2, last3;
  logic [CNT_W-1:0] taps1, taps2, taps3;
  logic             ovf1, ovf2, ovf3;
  logic [7:0]       opmode;
  logic             in_rdy;
  logic             accept;
  logic             inc, dec;
  logic             fifo_valid;
  logic [RES_W-1:0] fifo_dout;

  // Slice reset is held two cycles past RST_N release to flush its
  // synchronous registers before any beat is accepted.
  assign bus.dsp_rst = (rst_cnt != 2'd0);

  assign in_rdy = !bus.dsp_rst && (credits < CR_W'(RES_DEPTH));
  assign accept = bus.in_valid && in_rdy;
  assign inc    = accept && bus.in_last;
  assign dec    = fifo_valid && bus.res_ready;

  always_comb begin
    taps_nxt = tap_cnt;
    ovf_nxt  = tap_ovf;
    if (state == ST_FIRST) begin
      taps_nxt = CNT_W'(1);
      ovf_nxt  = 1'b0;
    end else if (tap_cnt == TAP_MAX) begin
      ovf_nxt = 1'b1;
    end else begin
      taps_nxt = tap_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_FIRST;
      rst_cnt <= 2'd2;
      credits <= '0;
      a_hold  <= '0;
      b_hold  <= '0;
      tap_cnt <= '0;
      tap_ovf <= 1'b0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      first1  <= 1'b0;
      last1   <= 1'b0;
      last2   <= 1'b0;
      last3   <= 1'b0;
      taps1   <= '0;
      taps2   <= '0;
      taps3   <= '0;
      ovf1    <= 1'b0;
      ovf2    <= 1'b0;
      ovf3    <= 1'b0;
      opmode  <= OPM_ACC;
    end else begin
      if (rst_cnt != 2'd0) rst_cnt <= rst_cnt - 2'd1;

      if (accept) begin
        a_hold  <= bus.in_a;
        b_hold  <= bus.in_b;
        tap_cnt <= taps_nxt;
        tap_ovf <= ovf_nxt;
        state   <= bus.in_last ? ST_FIRST : ST_ACC;
      end

      v1     <= accept;
      first1 <= (state == ST_FIRST);
      last1  <= accept && bus.in_last;
      taps1  <= taps_nxt;
      ovf1   <= ovf_nxt;

      v2    <= v1;
      last2 <= last1;
      taps2 <= taps1;
      ovf2  <= ovf1;

      v3    <= v2;
      last3 <= last2;
      taps3 <= taps2;
      ovf3  <= ovf2;

      // Registered one stage early so it lines up with the beat at the P stage.
      opmode <= (v1 && first1) ? OPM_FIRST : OPM_ACC;

      case ({inc, dec})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = in_rdy;
  assign bus.dsp_a      = accept ? bus.in_a : a_hold;
  assign bus.dsp_b      = accept ? bus.in_b : b_hold;
  assign bus.dsp_cea    = accept;
  assign bus.dsp_ceb    = accept;
  assign bus.dsp_cem    = v1;
  assign bus.dsp_cep    = v2;
  assign bus.dsp_opmode = opmode;

  res_fifo #(
    .WIDTH (RES_W),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (v3 && last3),
    .din   ({bus.dsp_p, taps3, ovf3}),
    .pop   (bus.res_ready),
    .valid (fifo_valid),
    .dout  (fifo_dout)
  );

  assign bus.res_valid = fifo_valid;
  assign bus.res_sum   = fifo_dout[RES_W-1 -: P_W];
  assign bus.res_taps  = fifo_dout[CNT_W:1];
  assign bus.res_ovf   = fifo_dout[0];

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Bench for dsp_mac_seq: behavioural DSP48A1 slice, burst-level reference
// model feeding an expected-result queue, and a monitor that pops and
// compares whenever a result is handed over.
module tb_dsp_mac_seq;
  import dsp_pkg::*;

  localparam int CNT_W     = 3;
  localparam int RES_DEPTH = 2;
  localparam int TAP_MAX   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [P_W-1:0]   sum;
    logic [CNT_W-1:0] taps;
    logic             ovf;
  } res_t;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  dsp_mac_seq_if #(.CNT_W(CNT_W)) bus ();

  dsp_mac_seq #(
    .RES_DEPTH (RES_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural slice: A1/B1 -> M -> P, all sync-reset by dsp_rst.
  logic [A_W-1:0] s_a1 = '0;
  logic [B_W-1:0] s_b1 = '0;
  logic [M_W-1:0] s_m  = '0;
  logic [P_W-1:0] s_p  = '0;
  logic [P_W-1:0] s_x, s_z;
  assign bus.dsp_p = s_p;

  always_comb begin
    case (bus.dsp_opmode[1:0])
      2'b01:   s_x = {{(P_W-M_W){1'b0}}, s_m};
      2'b10:   s_x = s_p;
      default: s_x = '0;
    endcase
    s_z = (bus.dsp_opmode[3:2] == 2'b10) ? s_p : '0;
  end

  always @(posedge CLK) begin
    if (bus.dsp_rst) begin
      s_a1 <= '0; s_b1 <= '0; s_m <= '0; s_p <= '0;
    end else begin
      if (bus.dsp_cea) s_a1 <= bus.dsp_a;
      if (bus.dsp_ceb) s_b1 <= bus.dsp_b;
      if (bus.dsp_cem) s_m  <= s_a1 * s_b1;
      if (bus.dsp_cep) s_p  <= s_z + s_x;
    end
  end

  // Burst-level reference model
  res_t            exp_q[$];
  longint unsigned m_sum = 0;
  int              m_cnt = 0;
  logic            rand_rdy = 1'b0;

  task automatic model_accept(input logic [17:0] a, input logic [17:0] b, input logic last);
    res_t r;
    m_sum += longint'(a) * longint'(b);
    m_cnt++;
    if (last) begin
      r.sum  = m_sum[P_W-1:0];
      r.taps = (m_cnt > TAP_MAX) ? CNT_W'(TAP_MAX) : CNT_W'(m_cnt);
      r.ovf  = (m_cnt > TAP_MAX);
      exp_q.push_back(r);
      m_sum = 0;
      m_cnt = 0;
    end
  endtask

  // Handshake history, credit and post-reset age, observed at the clock
  logic h1 = 1'b0, h2 = 1'b0;
  int   cr_model = 0;
  int   rst_age  = 0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      h1 <= 1'b0; h2 <= 1'b0; cr_model <= 0; rst_age <= 0;
    end else begin
      h1 <= bus.in_valid && bus.in_ready;
      h2 <= h1;
      if (rst_age < 3) rst_age <= rst_age + 1;
      cr_model <= cr_model + ((bus.in_valid && bus.in_ready && bus.in_last) ? 1 : 0)
                           - ((bus.res_valid && bus.res_ready) ? 1 : 0);
    end
  end

  // Monitor / scoreboard
  always @(negedge CLK) begin : monitor
    res_t e, g;
    logic exp_rst;
    if (RST_N) begin
      exp_rst = (rst_age < 2);
      chk1("dsp_rst", bus.dsp_rst, exp_rst);
      chk1("in_ready", bus.in_ready, !exp_rst && (cr_model < RES_DEPTH));
      chk1("dsp_cea", bus.dsp_cea, bus.in_valid && bus.in_ready);
      chk1("dsp_ceb", bus.dsp_ceb, bus.in_valid && bus.in_ready);
      chk1("dsp_cem", bus.dsp_cem, h1);
      chk1("dsp_cep", bus.dsp_cep, h2);
      chkv("opmode_hi", 64'(bus.dsp_opmode[7:4]), 64'(0));
      chk1("opmode_lo", (bus.dsp_opmode[3:0] == 4'h1) || (bus.dsp_opmode[3:0] == 4'h9), 1'b1);
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          chk1("unexpected_result", bus.res_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          g = {bus.res_sum, bus.res_taps, bus.res_ovf};
          chkv("result{sum,taps,ovf}", 64'(g), 64'(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rand_rdy) bus.res_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drive_beat(input logic [17:0] a, input logic [17:0] b, input logic last);
    logic rdy;
    int   n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    do begin
      @(negedge CLK);
      rdy = bus.in_ready;
      tick();
      n++;
    end while (!rdy && n < 200);
    if (!rdy) chk1("accept_timeout", rdy, 1'b1);
    else model_accept(a, b, last);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chkv("drain_timeout", 64'(exp_q.size()), 64'(0));
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.res_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    chk1("rst_dsp_rst", bus.dsp_rst, 1'b1);
    chk1("rst_cea", bus.dsp_cea, 1'b0);
    chk1("rst_cem", bus.dsp_cem, 1'b0);
    chk1("rst_cep", bus.dsp_cep, 1'b0);
    chkv("rst_dsp_a", 64'(bus.dsp_a), 64'(0));
    chkv("rst_dsp_b", 64'(bus.dsp_b), 64'(0));
    chkv("rst_opmode", 64'(bus.dsp_opmode), 64'h09);
    chk1("rst_res_valid", bus.res_valid, 1'b0);
    chkv("rst_res", 64'({bus.res_sum, bus.res_taps, bus.res_ovf}), 64'(0));
    tick();
    RST_N = 1'b1;
    repeat (3) tick();

    // 3-beat back-to-back burst, with latency of the result
    drive_beat(18'd3, 18'd4, 1'b0);
    drive_beat(18'd5, 18'd6, 1'b0);
    drive_beat(18'd7, 18'd8, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      chk1("latency_res_valid", bus.res_valid, (i == 4));
    end
    tick();
    wait_drain();

    // Single maximal beat
    drive_beat(18'h3FFFF, 18'h3FFFF, 1'b1);
    wait_drain();

    // Same burst with 2-cycle bubbles
    drive_beat(18'd3, 18'd4, 1'b0);
    idle(2);
    drive_beat(18'd5, 18'd6, 1'b0);
    idle(2);
    drive_beat(18'd7, 18'd8, 1'b1);
    wait_drain();

    // Credit back-pressure with results held
    bus.res_ready = 1'b0;
    drive_beat(18'd1, 18'd1, 1'b1);
    drive_beat(18'd2, 18'd2, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_a     = 18'd3;
    bus.in_b     = 18'd3;
    bus.in_last  = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      chk1("in_ready_full", bus.in_ready, 1'b0);
      tick();
    end
    bus.res_ready = 1'b1;
    drive_beat(18'd3, 18'd3, 1'b1);
    wait_drain();

    // Tap counter saturation (9 beats, 3-bit counter)
    for (int i = 0; i < 9; i++) drive_beat(18'd1, 18'd1, (i == 8));
    wait_drain();

    // Reset in the middle of a burst
    drive_beat(18'd5, 18'd5, 1'b0);
    drive_beat(18'd6, 18'd6, 1'b0);
    tick();
    RST_N = 1'b0;
    m_sum = 0;
    m_cnt = 0;
    @(negedge CLK);
    chk1("midrst_in_ready", bus.in_ready, 1'b0);
    chk1("midrst_dsp_rst", bus.dsp_rst, 1'b1);
    chk1("midrst_res_valid", bus.res_valid, 1'b0);
    tick();
    tick();
    RST_N = 1'b1;
    @(negedge CLK);
    chk1("post_rst_c0", bus.dsp_rst, 1'b1);
    tick();
    @(negedge CLK);
    chk1("post_rst_c1", bus.dsp_rst, 1'b1);
    tick();
    @(negedge CLK);
    chk1("post_rst_c2", bus.dsp_rst, 1'b0);
    chk1("post_rst_ready", bus.in_ready, 1'b1);
    tick();
    drive_beat(18'd2, 18'd3, 1'b1);
    wait_drain();

    // Randomized bursts with bubbles and result back-pressure
    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int len;
      len = $urandom_range(1, 10);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        drive_beat(18'($urandom_range(0, 18'h3FFFF)), 18'($urandom_range(0, 18'h3FFFF)),
                   (j == len - 1));
      end
    end
    rand_rdy = 1'b0;
    bus.res_ready = 1'b1;
    wait_drain();
    repeat (6) tick();
    chkv("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
